// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } pctrl_state_t;

    localparam logic [REG_W-1:0] XZR = 5'd31;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the datapath and stage enables/flush controls back to it.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_uses_rm;
    logic [4:0]       idex_rd;
    logic             idex_memtoreg;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwr_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output id_rn, id_rm, id_uses_rm, idex_rd, idex_memtoreg,
               br_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwr_en,
               ifid_flush, idex_bubble, mem_timeout, stall_cnt, state_dbg
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rm, idex_rd, idex_memtoreg,
               br_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwr_en,
               ifid_flush, idex_bubble, mem_timeout, stall_cnt, state_dbg
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: ID reads a register that the load in ID/EX is about to write.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_memtoreg,
    output logic             load_use
);

    // XZR is never written, so it can never be a producer.
    assign load_use = idex_memtoreg && (idex_rd != XZR) &&
                      ((idex_rd == id_rn) || (id_uses_rm && (idex_rd == id_rm)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-enable / flush / bubble sequencer for the 5-stage pipeline and PC.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYC   = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic             clk,
    input logic             reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned FC_W   = 3;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [FC_W-1:0]   FLUSH_RELOAD = FC_W'(FLUSH_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX     = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  STALL_MAX    = '1;

    pctrl_state_t      state, state_nxt;
    logic [FC_W-1:0]   flush_cnt, flush_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              timeout_q, timeout_nxt;
    logic [CNT_W-1:0]  stall_q;

    logic load_use, freeze, run_eval;
    logic pc_en, ifid_en, idex_en, exmem_en, memwr_en, ifid_flush, idex_bubble;

    hazard_detect u_hazard_detect (
        .id_rn         (bus.id_rn),
        .id_rm         (bus.id_rm),
        .id_uses_rm    (bus.id_uses_rm),
        .idex_rd       (bus.idex_rd),
        .idex_memtoreg (bus.idex_memtoreg),
        .load_use      (load_use)
    );

    assign freeze = bus.mem_req && !bus.mem_ready;

    // Next-state and same-cycle stage controls.
    always_comb begin
        state_nxt   = state;
        flush_nxt   = flush_cnt;
        wait_nxt    = wait_cnt;
        timeout_nxt = timeout_q;
        run_eval    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwr_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state)
            RUN: begin
                if (freeze) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwr_en} = 5'b00000;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwr_en} = 5'b00000;
                    if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_nxt == WAIT_MAX) timeout_nxt = 1'b1;
                end else begin
                    wait_nxt  = '0;
                    state_nxt = RUN;
                    run_eval  = 1'b1;
                end
            end
            FLUSH: begin
                if (freeze) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwr_en} = 5'b00000;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    flush_nxt   = bus.br_taken ? FLUSH_RELOAD : flush_cnt - FC_W'(1);
                    if (flush_nxt == '0) state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        // A taken branch squashes the younger instructions, so a load-use behind it is moot.
        if (run_eval) begin
            if (bus.br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (FLUSH_CYC > 1) begin
                    state_nxt = FLUSH;
                    flush_nxt = FLUSH_RELOAD;
                end
            end else if (load_use) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end

        if (!reset) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwr_en} = 5'b11111;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            wait_cnt  <= wait_nxt;
            timeout_q <= timeout_nxt;
            if (!pc_en && (stall_q != STALL_MAX)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwr_en    = memwr_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.state_dbg   = state;

endmodule
